// File: rtl/usb_tx_sched.sv
// Round-robin scheduler for two channel streams sharing one USB sync-FIFO write port.
// Each grant emits a header word followed by BURST payload words.
module usb_tx_sched #(
    parameter int unsigned BURST = 256,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          locked,
    input  logic [1:0]    en,
    input  logic [DW-1:0] ch0_tdata,
    input  logic          ch0_tvalid,
    output logic          ch0_tready,
    input  logic [DW-1:0] ch1_tdata,
    input  logic          ch1_tvalid,
    output logic          ch1_tready,
    input  logic          usb_txe_n,
    output logic          usb_wr_n,
    output logic [DW-1:0] usb_data,
    output logic [1:0]    grant,
    output logic          active
);

    localparam int unsigned CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] LAST = CW'(BURST - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_HDR,
        S_BURST,
        S_GAP
    } state_t;

    state_t          state, state_nx;
    logic            last_grant, last_grant_nx;
    logic [15:0]     seq0, seq0_nx;
    logic [15:0]     seq1, seq1_nx;
    logic [CW-1:0]   word_cnt, word_cnt_nx;
    logic [1:0]      grant_nx;
    logic            usb_wr_n_nx;
    logic [DW-1:0]   usb_data_nx;
    logic            active_nx;

    logic [1:0]      cand;
    logic            cur;
    logic            own_en;
    logic            acc;
    logic            other;
    logic [DW-1:0]   tdata_sel;

    // Ready is combinational so an abort (en or locked falling) blocks the same cycle.
    assign ch0_tready = grant[0] & ~usb_txe_n & (state == S_BURST) & en[0] & locked;
    assign ch1_tready = grant[1] & ~usb_txe_n & (state == S_BURST) & en[1] & locked;

    assign cand      = en & {ch1_tvalid, ch0_tvalid};
    assign cur       = grant[1];
    assign own_en    = |(grant & en);
    assign acc       = (ch0_tready & ch0_tvalid) | (ch1_tready & ch1_tvalid);
    assign other     = ~last_grant;
    assign tdata_sel = cur ? ch1_tdata : ch0_tdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            seq0       <= '0;
            seq1       <= '0;
            word_cnt   <= '0;
            grant      <= '0;
            usb_wr_n   <= 1'b1;
            usb_data   <= '0;
            active     <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            seq0       <= seq0_nx;
            seq1       <= seq1_nx;
            word_cnt   <= word_cnt_nx;
            grant      <= grant_nx;
            usb_wr_n   <= usb_wr_n_nx;
            usb_data   <= usb_data_nx;
            active     <= active_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        seq0_nx       = seq0;
        seq1_nx       = seq1;
        word_cnt_nx   = word_cnt;
        grant_nx      = grant;
        usb_wr_n_nx   = 1'b1;
        usb_data_nx   = usb_data;

        case (state)
            S_IDLE: begin
                if (locked) state_nx = S_ARB;
            end
            S_ARB: begin
                // The channel that did not go last has priority.
                if (cand[other]) begin
                    grant_nx      = other ? 2'b10 : 2'b01;
                    last_grant_nx = other;
                    word_cnt_nx   = '0;
                    state_nx      = S_HDR;
                end else if (cand[last_grant]) begin
                    grant_nx      = last_grant ? 2'b10 : 2'b01;
                    word_cnt_nx   = '0;
                    state_nx      = S_HDR;
                end
            end
            S_HDR: begin
                if (!own_en) begin
                    grant_nx = '0;
                    state_nx = S_GAP;
                end else if (!usb_txe_n) begin
                    usb_data_nx = DW'({8'hA5, 7'h0, cur, cur ? seq1 : seq0});
                    usb_wr_n_nx = 1'b0;
                    if (cur) seq1_nx = seq1 + 16'd1;
                    else     seq0_nx = seq0 + 16'd1;
                    state_nx    = S_BURST;
                end
            end
            S_BURST: begin
                if (!own_en) begin
                    grant_nx = '0;
                    state_nx = S_GAP;
                end else if (acc) begin
                    usb_data_nx = tdata_sel;
                    usb_wr_n_nx = 1'b0;
                    word_cnt_nx = word_cnt + CW'(1);
                    if (word_cnt == LAST) begin
                        grant_nx = '0;
                        state_nx = S_GAP;
                    end
                end
            end
            S_GAP: begin
                grant_nx = '0;
                state_nx = locked ? S_ARB : S_IDLE;
            end
            default: begin
                grant_nx = '0;
                state_nx = S_IDLE;
            end
        endcase

        // Losing the USB clock overrides everything; sequence and last owner survive.
        if (!locked) begin
            state_nx    = S_IDLE;
            grant_nx    = '0;
            usb_wr_n_nx = 1'b1;
            usb_data_nx = usb_data;
            seq0_nx     = seq0;
            seq1_nx     = seq1;
        end

        active_nx = (state_nx == S_HDR) || (state_nx == S_BURST);
    end

endmodule
